// File: rtl/nec_divider.sv
// Iterative restoring divider for DIVU/DIV, byte (16/8) and word (32/16).
// One quotient bit per cycle; signs are stripped in PREP and reapplied in FIX.
module nec_divider (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        wide,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_error,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t      state, state_nxt;

    // latched operands
    logic        wide_q, sgn_q;
    logic [31:0] dvd_q;
    logic [15:0] dvs_q;

    // working registers
    logic        qneg, rneg;
    logic [15:0] dvsm_q;   // divisor magnitude
    logic [15:0] rem_q;    // partial remainder (always < divisor magnitude)
    logic [15:0] shreg;    // dividend low bits out at MSB, quotient bits in at LSB
    logic [3:0]  cnt;

    // PREP datapath
    logic        dvd_neg, dvs_neg, pre_err;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag, dvs_low, upper, lower;

    // ITER / FIX datapath
    logic [16:0] shifted, trial;
    logic        ge, rng_err;
    logic [15:0] q_mag, r_mag, q_lim, q_fix, r_fix;

    // Magnitudes and pre-check; byte lower half is MSB-aligned so the next bit is always shreg[15]
    always_comb begin
        dvd_neg = sgn_q & (wide_q ? dvd_q[31] : dvd_q[15]);
        dvs_neg = sgn_q & (wide_q ? dvs_q[15] : dvs_q[7]);
        dvs_low = wide_q ? dvs_q : {8'h00, dvs_q[7:0]};
        if (wide_q) dvd_mag = dvd_neg ? 32'd0 - dvd_q : dvd_q;
        else        dvd_mag = {16'h0000, dvd_neg ? 16'd0 - dvd_q[15:0] : dvd_q[15:0]};
        if (wide_q) dvs_mag = dvs_neg ? 16'd0 - dvs_q : dvs_q;
        else        dvs_mag = {8'h00, dvs_neg ? 8'd0 - dvs_q[7:0] : dvs_q[7:0]};
        upper   = wide_q ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
        lower   = wide_q ? dvd_mag[15:0]  : {dvd_mag[7:0], 8'h00};
        pre_err = (dvs_low == 16'h0000) || (upper >= dvs_mag);
    end

    // Restoring step, sign fix-up and signed range check
    always_comb begin
        shifted = {rem_q, shreg[15]};
        ge      = shifted >= {1'b0, dvsm_q};
        trial   = shifted - {1'b0, dvsm_q};
        q_mag   = wide_q ? shreg : {8'h00, shreg[7:0]};
        r_mag   = wide_q ? rem_q : {8'h00, rem_q[7:0]};
        if (wide_q) q_lim = qneg ? 16'h8000 : 16'h7FFF;
        else        q_lim = qneg ? 16'h0080 : 16'h007F;
        rng_err = sgn_q & (q_mag > q_lim);
        if (wide_q) begin
            q_fix = qneg ? 16'd0 - q_mag : q_mag;
            r_fix = rneg ? 16'd0 - r_mag : r_mag;
        end else begin
            q_fix = {8'h00, qneg ? 8'd0 - q_mag[7:0] : q_mag[7:0]};
            r_fix = {8'h00, rneg ? 8'd0 - r_mag[7:0] : r_mag[7:0]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = PREP;
            PREP: begin
                busy      = 1'b1;
                state_nxt = pre_err ? DONE : ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == 4'd0) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers (loaded on entry to DONE)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wide_q    <= 1'b0;
            sgn_q     <= 1'b0;
            dvd_q     <= 32'h0;
            dvs_q     <= 16'h0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            dvsm_q    <= 16'h0;
            rem_q     <= 16'h0;
            shreg     <= 16'h0;
            cnt       <= 4'd0;
            div_error <= 1'b0;
            quotient  <= 16'h0;
            remainder <= 16'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wide_q <= wide;
                    sgn_q  <= signed_op;
                    dvd_q  <= dividend;
                    dvs_q  <= divisor;
                end
                PREP: begin
                    qneg   <= dvd_neg ^ dvs_neg;
                    rneg   <= dvd_neg;
                    dvsm_q <= dvs_mag;
                    rem_q  <= upper;
                    shreg  <= lower;
                    cnt    <= wide_q ? 4'd15 : 4'd7;
                    if (pre_err) begin
                        div_error <= 1'b1;
                        quotient  <= 16'h0;
                        remainder <= 16'h0;
                    end
                end
                ITER: begin
                    rem_q <= ge ? trial[15:0] : shifted[15:0];
                    shreg <= {shreg[14:0], ge};
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                FIX: begin
                    div_error <= rng_err;
                    quotient  <= rng_err ? 16'h0 : q_fix;
                    remainder <= rng_err ? 16'h0 : r_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nec_divider.sv
// Scoreboard bench for nec_divider: driver pushes expected results, monitor checks on done.
module tb_nec_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, wide, signed_op;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy, done, div_error;
    logic [15:0] quotient, remainder;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          lat;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    nec_divider dut (
        .clk(clk), .reset_n(reset_n), .start(start), .wide(wide), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_error(div_error), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // edge counter: after edge j, cyc == j
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_error", div_error, e.err);
                chk("latency", cyc + 1 - e.k, e.lat);
            end
        end
    end

    // one operation; lat is the expected start-to-done cycle count
    task automatic run_op(input logic w, input logic s, input logic [31:0] dd, input logic [15:0] ds,
                          input logic [15:0] eq, input logic [15:0] er, input logic ee,
                          input int lat, input bit glitch);
        int  bc;
        bit  seen;
        exp_t e;
        @(negedge clk);
        wide = w; signed_op = s; dividend = dd; divisor = ds; start = 1'b1;
        @(posedge clk);
        #1;
        e.q = eq; e.r = er; e.err = ee; e.lat = lat; e.k = cyc;
        sb.push_back(e);
        // scramble inputs: the running operation must use latched operands
        start = 1'b0; wide = ~w; signed_op = ~s; dividend = 32'h0F0F_0F0F; divisor = 16'h0007;
        bc = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (glitch && i == 5) start = 1'b1;
            if (glitch && i == 6) start = 1'b0;
            if (busy) bc = bc + 1;
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
        chk("busy_cycles", bc, lat - 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; wide = 1'b0; signed_op = 1'b0;
        dividend = 32'h0; divisor = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", div_error, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        reset_n = 1'b1;
        @(negedge clk);

        //     w  s  dividend       divisor   q         r         err lat glitch
        run_op(1, 0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 0, 19, 0);
        run_op(0, 0, 32'hABCD_00FF, 16'h7710, 16'h000F, 16'h000F, 0, 11, 0);
        run_op(1, 0, 32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1,  2, 0);
        run_op(0, 0, 32'h0000_1000, 16'h0010, 16'h0000, 16'h0000, 1,  2, 0);
        run_op(0, 1, 32'h0000_FF9C, 16'h5507, 16'h00F2, 16'h00FE, 0, 11, 0);
        run_op(0, 1, 32'h0000_FF80, 16'h00FF, 16'h0000, 16'h0000, 1, 11, 0);
        run_op(1, 1, 32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 0, 19, 0);
        run_op(1, 1, 32'h0000_8000, 16'h0001, 16'h0000, 16'h0000, 1, 19, 0);
        run_op(1, 1, 32'h0000_0064, 16'hFFF9, 16'hFFF2, 16'h0002, 0, 19, 0);
        run_op(1, 0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 0, 19, 1);

        // reset in ITER cycle 5 of a word op: everything clears, no done follows
        @(negedge clk);
        wide = 1'b1; signed_op = 1'b0; dividend = 32'h0001_0000; divisor = 16'h0003; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", div_error, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        run_op(0, 0, 32'h0000_00FF, 16'h0010, 16'h000F, 16'h000F, 0, 11, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
